// File: rtl/gc_cmd_pkg.sv
// gc_cmd_pkg: opcodes, response IDs, lengths
// and state encoding for the GameCube link.
package gc_cmd_pkg;

  localparam logic [7:0]  CMD_PROBE      = 8'h00;
  localparam logic [15:0] CMD_POLL       = 16'h4003;
  localparam logic [7:0]  CMD_PAIR_DEF   = 8'h4E;

  localparam logic [7:0]  ID_WIRED       = 8'h09;
  localparam logic [7:0]  ID_WB_NOTREADY = 8'hA8;

  localparam logic [4:0]  LEN_SHORT      = 5'd8;
  localparam logic [4:0]  LEN_LONG       = 5'd24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE_REQ,
    ST_PROBE_WAIT,
    ST_PAIR_REQ,
    ST_PAIR_WAIT,
    ST_GAP,
    ST_POLL_REQ,
    ST_POLL_WAIT
  } gc_state_t;

  // Zero-length intervals would never expire; run them as one cycle.
  function automatic logic [31:0] at_least_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/gc_cyc_timer.sv
// gc_cyc_timer: loadable 32-bit down-counter.
// expired flags the cycle on which it steps to 0.
module gc_cyc_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] value,
  output logic        expired
);

  logic [31:0] cnt;

  // Load wins over counting; the count parks at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 32'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 32'd0) begin
      cnt <= cnt - 32'd1;
    end
  end

  assign value   = cnt;
  assign expired = (cnt == 32'd1);

endmodule

// File: rtl/gc_link_scheduler.sv
// gc_link_scheduler: probe / WaveBird pairing /
// periodic poll sequencer for one controller link.
module gc_link_scheduler
  import gc_cmd_pkg::*;
#(
  parameter int unsigned POLL_GAP_CYC     = 1000000,
  parameter int unsigned RESP_TIMEOUT_CYC = 50000,
  parameter int unsigned MAX_MISSES       = 4,
  parameter logic [7:0]  PAIR_OPCODE      = CMD_PAIR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rumble,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [23:0] tx_cmd,
  output logic [4:0]  tx_bits,
  input  logic        rx_valid,
  input  logic [23:0] rx_id,
  output logic        link_up,
  output logic        is_wavebird,
  output logic [2:0]  miss_cnt,
  output logic        poll_ok
);

  localparam logic [31:0] GAP_C  = at_least_one(POLL_GAP_CYC);
  localparam logic [31:0] TMO_C  = at_least_one(RESP_TIMEOUT_CYC);
  localparam logic [31:0] MISS_C = at_least_one(MAX_MISSES);

  gc_state_t   state;
  logic        hs;
  logic        in_wait;
  logic        tmr_load;
  logic [31:0] tmr_val;
  logic [31:0] tmr_value;
  logic        tmr_expired;
  logic        tmr_done;
  logic [2:0]  miss_nxt;
  logic        drop;
  logic        id_wired;
  logic        id_nready;

  assign hs        = tx_valid & tx_ready;
  assign in_wait   = (state == ST_PROBE_WAIT) |
                     (state == ST_PAIR_WAIT)  |
                     (state == ST_POLL_WAIT);
  assign tmr_done  = tmr_expired | (tmr_value == 32'd0);
  assign tmr_load  = hs | (in_wait & (rx_valid | tmr_done));
  assign tmr_val   = hs ? TMO_C : GAP_C;
  assign miss_nxt  = (miss_cnt == 3'd7) ? 3'd7 : miss_cnt + 3'd1;
  assign drop      = ({29'd0, miss_nxt} >= MISS_C);
  assign id_wired  = (rx_id[23:16] == ID_WIRED);
  assign id_nready = (rx_id[23:16] == ID_WB_NOTREADY);

  // Gap and response windows never overlap, so one timer serves both.
  gc_cyc_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expired  (tmr_expired)
  );

  // Link sequencer with registered command and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tx_valid    <= 1'b0;
      tx_cmd      <= 24'd0;
      tx_bits     <= 5'd0;
      link_up     <= 1'b0;
      is_wavebird <= 1'b0;
      miss_cnt    <= 3'd0;
      poll_ok     <= 1'b0;
    end else begin
      poll_ok <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_PROBE_REQ;
            tx_valid <= 1'b1;
            tx_cmd   <= {CMD_PROBE, 16'h0000};
            tx_bits  <= LEN_SHORT;
          end
        end
        ST_PROBE_REQ: begin
          if (hs) begin
            tx_valid <= 1'b0;
            state    <= ST_PROBE_WAIT;
          end
        end
        ST_PROBE_WAIT: begin
          if (rx_valid) begin
            unique case (1'b1)
              id_wired: begin
                link_up     <= 1'b1;
                is_wavebird <= 1'b0;
                state       <= ST_GAP;
              end
              id_nready: begin
                link_up     <= 1'b0;
                is_wavebird <= 1'b0;
                state       <= ST_GAP;
              end
              default: begin
                state    <= ST_PAIR_REQ;
                tx_valid <= 1'b1;
                tx_cmd   <= {PAIR_OPCODE, rx_id[15:0]};
                tx_bits  <= LEN_LONG;
              end
            endcase
          end else if (tmr_done) begin
            link_up     <= 1'b0;
            is_wavebird <= 1'b0;
            state       <= ST_GAP;
          end
        end
        ST_PAIR_REQ: begin
          if (hs) begin
            tx_valid <= 1'b0;
            state    <= ST_PAIR_WAIT;
          end
        end
        ST_PAIR_WAIT: begin
          if (rx_valid | tmr_done) begin
            link_up     <= 1'b1;
            is_wavebird <= 1'b1;
            state       <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_done) begin
            if (!enable) begin
              state <= ST_IDLE;
            end else if (link_up) begin
              state    <= ST_POLL_REQ;
              tx_valid <= 1'b1;
              tx_cmd   <= {CMD_POLL, 7'd0, rumble};
              tx_bits  <= LEN_LONG;
            end else begin
              state    <= ST_PROBE_REQ;
              tx_valid <= 1'b1;
              tx_cmd   <= {CMD_PROBE, 16'h0000};
              tx_bits  <= LEN_SHORT;
            end
          end
        end
        ST_POLL_REQ: begin
          if (hs) begin
            tx_valid <= 1'b0;
            state    <= ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
          if (rx_valid) begin
            poll_ok  <= 1'b1;
            miss_cnt <= 3'd0;
            state    <= ST_GAP;
          end else if (tmr_done) begin
            if (drop) begin
              link_up     <= 1'b0;
              is_wavebird <= 1'b0;
              miss_cnt    <= 3'd0;
            end else begin
              miss_cnt <= miss_nxt;
            end
            state <= ST_GAP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_link_scheduler.sv
// tb_gc_link_scheduler: directed + randomized link
// sequencing checked against a transaction-level model.
module tb_gc_link_scheduler;

  localparam int G  = 20;
  localparam int T  = 10;
  localparam int MM = 4;
  localparam int K_PROBE = 0;
  localparam int K_PAIR  = 1;
  localparam int K_POLL  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rumble;
  logic        tx_valid;
  logic        tx_ready;
  logic [23:0] tx_cmd;
  logic [4:0]  tx_bits;
  logic        rx_valid;
  logic [23:0] rx_id;
  logic        link_up;
  logic        is_wavebird;
  logic [2:0]  miss_cnt;
  logic        poll_ok;

  int total = 0;
  int bad   = 0;

  int          m_kind;
  bit          m_link;
  bit          m_wb;
  int          m_miss;
  logic [15:0] m_id16;
  int          exp_gap;
  int          force_rumble;

  always #5 clk = ~clk;

  gc_link_scheduler #(
    .POLL_GAP_CYC     (G),
    .RESP_TIMEOUT_CYC (T),
    .MAX_MISSES       (MM),
    .PAIR_OPCODE      (8'h4E)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rumble      (rumble),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_cmd      (tx_cmd),
    .tx_bits     (tx_bits),
    .rx_valid    (rx_valid),
    .rx_id       (rx_id),
    .link_up     (link_up),
    .is_wavebird (is_wavebird),
    .miss_cnt    (miss_cnt),
    .poll_ok     (poll_ok)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input bit e_ok);
    chk("link_up", link_up, m_link);
    chk("is_wavebird", is_wavebird, m_wb);
    chk("miss_cnt", miss_cnt, m_miss);
    chk("poll_ok", poll_ok, e_ok);
  endtask

  // One full transaction: wait for a request, check it, handshake,
  // then answer after d cycles or let it time out.
  task automatic txn(input bit respond, input int d,
                     input logic [23:0] id, input int bp,
                     input bit drop_en);
    int          k;
    logic        r_s;
    logic [23:0] e_cmd;
    logic [4:0]  e_bits;
    bit          e_ok;
    logic [31:0] rv;
    k   = 0;
    r_s = rumble;
    while (!tx_valid && k < G + T + 20) begin
      if (force_rumble >= 0) rumble = force_rumble[0];
      else rumble = 1'($urandom_range(0, 1));
      r_s      = rumble;
      rv       = $urandom;
      rx_id    = rv[23:0];
      rx_valid = (rv[31:29] == 3'd0);
      cyc();
      rx_valid = 1'b0;
      k++;
    end
    chk("req_valid", tx_valid, 1);
    if (exp_gap >= 0) chk("gap_len", k, exp_gap);
    case (m_kind)
      K_PROBE: begin e_cmd = 24'h000000; e_bits = 5'd8; end
      K_PAIR:  begin e_cmd = {8'h4E, m_id16}; e_bits = 5'd24; end
      default: begin e_cmd = {16'h4003, 7'd0, r_s}; e_bits = 5'd24; end
    endcase
    chk("req_cmd", tx_cmd, e_cmd);
    chk("req_bits", tx_bits, e_bits);
    for (int i = 0; i < bp; i++) begin
      if (drop_en) enable = 1'b0;
      rumble   = ~rumble;
      tx_ready = 1'b0;
      cyc();
      chk("hold_valid", tx_valid, 1);
      chk("hold_cmd", tx_cmd, e_cmd);
    end
    tx_ready = 1'b1;
    rv       = $urandom;
    rx_valid = rv[0];
    rx_id    = rv[24:1];
    cyc();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    if (drop_en) enable = 1'b1;
    chk("post_hs_valid", tx_valid, 0);
    if (respond) begin
      repeat (d) cyc();
      rx_valid = 1'b1;
      rx_id    = id;
      cyc();
      rx_valid = 1'b0;
    end else begin
      repeat (T) cyc();
    end
    e_ok    = 1'b0;
    exp_gap = G;
    case (m_kind)
      K_PROBE: begin
        if (!respond) begin
          m_link = 1'b0; m_wb = 1'b0;
        end else if (id[23:16] == 8'h09) begin
          m_link = 1'b1; m_wb = 1'b0; m_kind = K_POLL;
        end else if (id[23:16] == 8'hA8) begin
          m_link = 1'b0; m_wb = 1'b0;
        end else begin
          m_id16 = id[15:0]; m_kind = K_PAIR; exp_gap = 0;
        end
      end
      K_PAIR: begin
        m_link = 1'b1; m_wb = 1'b1; m_kind = K_POLL;
      end
      default: begin
        if (respond) begin
          m_miss = 0; e_ok = 1'b1;
        end else begin
          m_miss = (m_miss < 7) ? m_miss + 1 : 7;
          if (m_miss >= MM) begin
            m_link = 1'b0; m_wb = 1'b0; m_miss = 0; m_kind = K_PROBE;
          end
        end
      end
    endcase
    chk_status(e_ok);
  endtask

  initial begin
    int          r;
    int          d;
    logic [31:0] rv;
    logic [23:0] id;
    int          k;
    rst          = 1'b0;
    enable       = 1'b0;
    rumble       = 1'b0;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    rx_id        = 24'd0;
    force_rumble = -1;
    m_kind = K_PROBE; m_link = 0; m_wb = 0; m_miss = 0;
    m_id16 = 16'd0; exp_gap = -1;
    #2 rst = 1'b1;
    repeat (3) cyc();
    chk("rst_valid", tx_valid, 0);
    chk("rst_cmd", tx_cmd, 0);
    chk("rst_bits", tx_bits, 0);
    chk_status(1'b0);
    rst = 1'b0;
    cyc();
    chk("idle_no_req", tx_valid, 0);

    // wired bring-up, then polls
    enable = 1'b1;
    txn(1, 0, 24'h090000, 0, 0);
    txn(1, 3, 24'h000000, 0, 0);
    // backpressure with enable dropped and rumble forced on
    force_rumble = 1;
    txn(1, 2, 24'h000000, 50, 1);
    force_rumble = -1;

    // misses, recovery, then link drop
    txn(0, 0, 24'h0, 0, 0);
    txn(0, 0, 24'h0, 0, 0);
    txn(0, 0, 24'h0, 0, 0);
    txn(1, 5, 24'h0, 0, 0);
    repeat (MM) txn(0, 0, 24'h0, 1, 0);

    // WaveBird: not ready, re-probe, pair
    txn(1, 2, 24'hA80000, 0, 0);
    txn(1, 1, 24'hE91234, 0, 0);
    txn(1, 3, 24'h123456, 2, 0);

    // response on the exact timeout cycle
    txn(1, T - 1, 24'h0, 0, 0);

    // enable low at gap expiry parks in IDLE, link held
    enable = 1'b0;
    repeat (G + 5) cyc();
    chk("idle_park", tx_valid, 0);
    chk("idle_link", link_up, 1);
    enable  = 1'b1;
    m_kind  = K_PROBE;
    exp_gap = -1;
    txn(1, 4, 24'h09ABCD, 0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 3);
      d  = $urandom_range(0, T - 1);
      rv = $urandom;
      id = rv[23:0];
      case (m_kind)
        K_PROBE: begin
          if (m_link) begin
            txn(1, d, {8'h09, id[15:0]}, r, 0);
          end else begin
            case (r)
              0: txn(1, d, {8'h09, id[15:0]}, 0, 0);
              1: txn(1, d, {8'hA8, id[15:0]}, 1, 0);
              2: begin
                if (id[23:16] == 8'h09 || id[23:16] == 8'hA8)
                  id[23:16] = 8'h55;
                txn(1, d, id, 0, 0);
              end
              default: txn(0, 0, id, 2, 0);
            endcase
          end
        end
        K_PAIR:  txn(r != 0, d, id, r, 0);
        default: txn(r < 2, d, id, r, 0);
      endcase
    end

    // reach POLL_WAIT, then reset asynchronously
    for (int j = 0; j < 3 && m_kind != K_POLL; j++)
      txn(1, 2, 24'h090000, 0, 0);
    k = 0;
    while (!tx_valid && k < G + T + 20) begin
      cyc();
      k++;
    end
    chk("pre_rst_req", tx_valid, 1);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    repeat (3) cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_cmd", tx_cmd, 0);
    chk("arst_bits", tx_bits, 0);
    m_link = 0; m_wb = 0; m_miss = 0; m_kind = K_PROBE; exp_gap = -1;
    chk_status(1'b0);
    cyc();
    rst = 1'b0;
    txn(1, 1, 24'h090000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gc_link_scheduler.md
Name: gc_link_scheduler

Overview:
- Sequences all traffic on one GameCube controller serial link: probe, WaveBird pairing, then periodic button polling with rumble.
- Sits between system control/rumble logic and the bit-serial command transmitter/response receiver.
- Owns link bring-up, response timeouts, miss counting and automatic re-initialisation.

Parameters:
- POLL_GAP_CYC, 1000000, idle cycles between the end of one transaction and the next command (10 ms at 100 MHz).
- RESP_TIMEOUT_CYC, 50000, cycles from command accept to declared timeout.
- MAX_MISSES, 4, consecutive poll timeouts that drop the link.
- PAIR_OPCODE, 8'h4E, first byte of the WaveBird pairing command.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-high
- enable  in  1  allows new transactions
- rumble  in  1  rumble request, sampled at each poll issue
- tx_valid  out  1  command request to transmitter
- tx_ready  in  1  transmitter accepts; handshake completes when tx_valid&tx_ready
- tx_cmd  out  24  command, MSB-first; 8-bit commands are left-aligned in [23:16]
- tx_bits  out  5  command length, 8 or 24
- rx_valid  in  1  one-cycle pulse: response received
- rx_id  in  24  first 24 response bits
- link_up  out  1  polling is active
- is_wavebird  out  1  link was paired through the WaveBird path
- miss_cnt  out  3  consecutive poll timeouts
- poll_ok  out  1  one-cycle pulse on each poll response

Behaviour:
- Reset: state IDLE; tx_valid=0, tx_cmd=0, tx_bits=0, link_up=0, is_wavebird=0, miss_cnt=0, poll_ok=0; timers cleared. Asserting rst mid-transaction aborts immediately, with no handshake completion.
- States: IDLE, PROBE_REQ, PROBE_WAIT, PAIR_REQ, PAIR_WAIT, GAP, POLL_REQ, POLL_WAIT.
- IDLE -> PROBE_REQ when enable=1.
- *_REQ:
  - tx_valid=1, with tx_cmd/tx_bits stable until handshake.
  - Never drop tx_valid before handshake, even if enable falls.
  - Handshake cycle -> matching *_WAIT; load timeout = RESP_TIMEOUT_CYC.
- PROBE_REQ: tx_cmd=24'h000000, tx_bits=8.
- PROBE_WAIT, on rx_valid:
  - rx_id[23:16]==8'h09 (wired): is_wavebird=0, link_up=1 -> GAP.
  - ==8'hA8 (WaveBird not ready): -> GAP, then re-probe.
  - Any other value: latch rx_id -> PAIR_REQ.
- PROBE_WAIT on timeout: -> GAP, then re-probe.
- PAIR_REQ: tx_cmd={PAIR_OPCODE, latched_id[15:0]}, tx_bits=24.
- PAIR_WAIT:
  - rx_valid or timeout -> is_wavebird=1, link_up=1, GAP.
  - Pairing has no response check.
- GAP:
  - Count POLL_GAP_CYC cycles.
  - At expiry, go to POLL_REQ if link_up, else PROBE_REQ.
  - If enable=0 at expiry, go to IDLE instead; link_up is held.
- POLL_REQ: tx_cmd={8'h40, 8'h03, 7'b0, rumble_sampled}, tx_bits=24. rumble is sampled on entry to POLL_REQ.
- POLL_WAIT:
  - rx_valid: poll_ok=1 for 1 cycle, miss_cnt=0 -> GAP.
  - Timeout: miss_cnt+1 (saturating at 7) -> GAP.
  - If miss_cnt reaches MAX_MISSES: link_up=0, is_wavebird=0, miss_cnt=0 -> GAP, then re-probe.
- Timeout fires on the cycle the counter reaches 0, i.e. exactly RESP_TIMEOUT_CYC cycles after handshake.
- rx_valid coincident with timeout: response wins.
- rx_valid outside a *_WAIT state is ignored, with no state change.
- rx_valid on the handshake cycle itself is ignored.
- Gap and timeout counters are 32-bit. Parameters of 0 are treated as 1.

Decomposition:
- gc_cmd_pkg holds:
  - Opcode constants: CMD_PROBE 8'h00, CMD_POLL 16'h4003, default pair 8'h4E.
  - ID constants: ID_WIRED 8'h09, ID_WB_NOTREADY 8'hA8.
  - Length constants: 8 and 24.
  - State encoding.
- One sub-module, gc_cyc_timer: loadable 32-bit down-counter with load, value and expired outputs. Instantiate it once; GAP and *_WAIT share it because they never overlap.

Test Plan:
- Wired path, with POLL_GAP_CYC=20, RESP_TIMEOUT_CYC=10:
  - Stimulus: enable, tx_ready=1; answer probe with rx_id=24'h090000.
  - Required: tx_cmd=0/tx_bits=8, then link_up=1, is_wavebird=0; 20 cycles later tx_cmd=24'h400300.
- WaveBird pairing:
  - Stimulus: probe response rx_id=24'hA80000, then after the gap 24'hE91234.
  - Required: first re-probe, then tx_cmd=24'h4E1234 with tx_bits=24; on rx_valid, is_wavebird=1, link_up=1.
- Rumble:
  - Stimulus: rumble=1 before POLL_REQ entry, toggled during the request.
  - Required: tx_cmd=24'h400301 stable until handshake.
- Link drop:
  - Stimulus: link up, MAX_MISSES=4, no rx_valid.
  - Required: miss_cnt steps 1,2,3; 4th timeout gives link_up=0; next command is a probe. Any rx_valid between misses resets miss_cnt to 0 and pulses poll_ok.
- Backpressure and race:
  - Stimulus 1: tx_ready=0 for 50 cycles with enable dropped. Required: tx_valid held with tx_cmd stable.
  - Stimulus 2: rx_valid on the exact timeout cycle. Required: poll_ok=1, miss_cnt unchanged.
- Reset mid-wait:
  - Stimulus: assert rst asynchronously in POLL_WAIT.
  - Required: all outputs 0 on the same edge; after release with enable=1, tx_cmd=0 (probe).
